rv32i_alu_seq: RTL and testbench

Multi-cycle execution unit sitting downstream of the ALU decoder; consumes the one-hot operation vector (ALU and branch ops) plus two 32-bit operands.
- Single-cycle compute for add/sub/logic/compare/branch.
- Shifts via an iterative 1-bit-per-cycle shifter (area-lean MCU target).
- Handshake: start/ready in, one-cycle done pulse out; result and branch decision held until next accept.

---
 rtl/rv32i_alu_seq.sv | 139 +++++++++++++
 tb/tb_rv32i_alu_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_alu_seq.sv
// Multi-cycle RV32I execution unit: single-cycle ALU/branch evaluation plus an
// iterative 1-bit-per-cycle shifter, with a start/ready in, done-pulse out handshake.
module rv32i_alu_seq #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [15:0]     op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic            br_taken_o,
  output logic            err_o
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shift_kind_t;

  state_t               state_q, state_d;
  shift_kind_t          kind_q;
  logic [XLEN-1:0]      shreg_q;
  logic [SHAMT_W-1:0]   count_q;

  logic                 accept;
  logic                 legal;
  logic                 is_shift;
  logic                 go_shift;
  logic [SHAMT_W-1:0]   shamt;
  logic                 lt_s, lt_u, eq;
  logic [XLEN-1:0]      alu_res;
  logic                 br_res;
  logic [XLEN-1:0]      sh_next;

  assign accept   = start_i && (state_q == S_IDLE);
  assign legal    = (op_i != '0) && ((op_i & (op_i - 16'd1)) == '0);
  assign shamt    = b_i[SHAMT_W-1:0];
  assign is_shift = op_i[2] || op_i[6] || op_i[7];
  assign go_shift = legal && is_shift && (shamt != '0);

  assign lt_s = $signed(a_i) < $signed(b_i);
  assign lt_u = a_i < b_i;
  assign eq   = a_i == b_i;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_res = '0;
    br_res  = 1'b0;
    case (1'b1)
      op_i[0]:  alu_res = a_i + b_i;
      op_i[1]:  alu_res = a_i - b_i;
      // Shifts only reach this path with a zero shift amount, so the result is a_i.
      op_i[2],
      op_i[6],
      op_i[7]:  alu_res = a_i;
      op_i[3]:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
      op_i[4]:  alu_res = {{(XLEN-1){1'b0}}, lt_u};
      op_i[5]:  alu_res = a_i ^ b_i;
      op_i[8]:  alu_res = a_i | b_i;
      op_i[9]:  alu_res = a_i & b_i;
      op_i[10]: br_res  = eq;
      op_i[11]: br_res  = !eq;
      op_i[12]: br_res  = lt_s;
      op_i[13]: br_res  = !lt_s;
      op_i[14]: br_res  = lt_u;
      op_i[15]: br_res  = !lt_u;
      default: ;
    endcase
  end

  always_comb begin
    sh_next = shreg_q;
    case (kind_q)
      SH_LL:   sh_next = {shreg_q[XLEN-2:0], 1'b0};
      SH_RL:   sh_next = {1'b0, shreg_q[XLEN-1:1]};
      SH_RA:   sh_next = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
      default: sh_next = shreg_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = go_shift ? S_SHIFT : S_DONE;
      S_SHIFT: if (count_q == SHAMT_W'(1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; all datapath registers are reset because they drive outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      kind_q     <= SH_LL;
      shreg_q    <= '0;
      count_q    <= '0;
      result_o   <= '0;
      br_taken_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (go_shift) begin
              shreg_q    <= a_i;
              count_q    <= shamt;
              kind_q     <= op_i[2] ? SH_LL : (op_i[6] ? SH_RL : SH_RA);
              result_o   <= '0;
              br_taken_o <= 1'b0;
              err_o      <= 1'b0;
            end else begin
              result_o   <= legal ? alu_res : '0;
              br_taken_o <= legal && br_res;
              err_o      <= !legal;
            end
          end
        end
        S_SHIFT: begin
          shreg_q <= sh_next;
          count_q <= count_q - SHAMT_W'(1);
          if (count_q == SHAMT_W'(1)) result_o <= sh_next;
        end
        default: ;
      endcase
    end
  end

  assign ready_o = (state_q == S_IDLE);
  assign busy_o  = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign done_o  = (state_q == S_DONE);

endmodule

// File: tb/tb_rv32i_alu_seq.sv
// Self-checking bench for rv32i_alu_seq: a behavioural op/latency model checked
// every cycle, directed corner cases with literal expectations, then random ops.
module tb_rv32i_alu_seq;

  localparam logic [15:0] OP_ADD  = 16'h0001;
  localparam logic [15:0] OP_SUB  = 16'h0002;
  localparam logic [15:0] OP_SLL  = 16'h0004;
  localparam logic [15:0] OP_SRL  = 16'h0040;
  localparam logic [15:0] OP_SRA  = 16'h0080;
  localparam logic [15:0] OP_BEQ  = 16'h0400;
  localparam logic [15:0] OP_BLT  = 16'h1000;
  localparam logic [15:0] OP_BLTU = 16'h4000;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [15:0] op_i;
  logic [31:0] a_i, b_i;
  logic        ready_o, busy_o, done_o, br_taken_o, err_o;
  logic [31:0] result_o;

  int n_checks = 0;
  int n_errors = 0;

  rv32i_alu_seq #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .br_taken_o(br_taken_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] res;
    logic        br;
    logic        err;
    int          lat;
  } exp_t;

  // Reference semantics straight from the ISA rules: plain arithmetic on the operands.
  function automatic exp_t ref_op(input logic [15:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   idx;
    int   n;
    e.res = 32'd0;
    e.br  = 1'b0;
    e.err = 1'b0;
    e.lat = 1;
    if ($countones(op) != 1) begin
      e.err = 1'b1;
      return e;
    end
    idx = 0;
    for (int k = 0; k < 16; k++) if (op[k]) idx = k;
    n = int'(b[4:0]);
    case (idx)
      0:  e.res = a + b;
      1:  e.res = a - b;
      2:  begin e.res = a << n; e.lat = n + 1; end
      3:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4:  e.res = (a < b) ? 32'd1 : 32'd0;
      5:  e.res = a ^ b;
      6:  begin e.res = a >> n; e.lat = n + 1; end
      7:  begin e.res = 32'($signed(a) >>> n); e.lat = n + 1; end
      8:  e.res = a | b;
      9:  e.res = a & b;
      10: e.br = (a == b);
      11: e.br = (a != b);
      12: e.br = ($signed(a) < $signed(b));
      13: e.br = ($signed(a) >= $signed(b));
      14: e.br = (a < b);
      default: e.br = (a >= b);
    endcase
    return e;
  endfunction

  // Model: m_lat==0 means idle; otherwise m_cyc counts cycles since the accept edge.
  int          m_lat, m_cyc;
  logic [31:0] m_res;
  logic        m_br, m_err;

  always @(posedge clk_i or negedge rst_ni) begin
    exp_t e;
    if (!rst_ni) begin
      m_lat <= 0; m_cyc <= 0; m_res <= '0; m_br <= 1'b0; m_err <= 1'b0;
    end else if (m_lat == 0) begin
      if (start_i) begin
        e = ref_op(op_i, a_i, b_i);
        m_res <= e.res; m_br <= e.br; m_err <= e.err;
        m_lat <= e.lat; m_cyc <= 1;
      end
    end else if (m_cyc == m_lat) begin
      m_lat <= 0; m_cyc <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
    end
  end

  always @(negedge clk_i) begin
    logic exp_done;
    exp_done = (m_lat != 0) && (m_cyc == m_lat);
    check("ready", ready_o, m_lat == 0);
    check("busy", busy_o, m_lat != 0);
    check("done", done_o, exp_done);
    if (m_lat == 0 || exp_done) begin
      check("result", result_o, m_res);
      check("br_taken", br_taken_o, m_br);
      check("err", err_o, m_err);
    end
  end

  task automatic wait_ready();
    int g = 0;
    @(negedge clk_i);
    while (!ready_o && g < 100) begin @(negedge clk_i); g++; end
    check("ready_wait", ready_o, 1'b1);
  endtask

  task automatic run_op(input logic [15:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic br, output logic err, output int lat);
    wait_ready();
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0; op_i = 16'($urandom); a_i = $urandom; b_i = $urandom;
    lat = 1;
    while (!done_o && lat < 100) begin @(negedge clk_i); lat++; end
    check("done_seen", done_o, 1'b1);
    res = result_o; br = br_taken_o; err = err_o;
  endtask

  initial begin
    logic [31:0] r;
    logic        br, er;
    int          lat, d1, d2, nd;
    logic [15:0] rop;
    logic [31:0] rb;

    rst_ni = 1'b0; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_ready", ready_o, 1'b1);
    check("rst_result", result_o, 32'd0);
    rst_ni = 1'b1;

    run_op(OP_ADD, 32'hFFFF_FFFF, 32'h2, r, br, er, lat);
    check("add_res", r, 32'h1); check("add_br", br, 1'b0);
    check("add_err", er, 1'b0); check("add_lat", lat, 1);
    run_op(OP_SUB, 32'h0, 32'h1, r, br, er, lat);
    check("sub_res", r, 32'hFFFF_FFFF);

    // Abort a long shift with an asynchronous reset mid-cycle.
    wait_ready();
    start_i = 1'b1; op_i = OP_SLL; a_i = 32'h1; b_i = 32'd31;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("abort_ready", ready_o, 1'b1);
    check("abort_busy", busy_o, 1'b0);
    check("abort_done", done_o, 1'b0);
    check("abort_result", result_o, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    run_op(OP_SRA, 32'h8000_0000, 32'h1F, r, br, er, lat);
    check("sra_res", r, 32'hFFFF_FFFF); check("sra_lat", lat, 32);
    run_op(OP_SRL, 32'h8000_0000, 32'h1F, r, br, er, lat);
    check("srl_res", r, 32'h1);
    run_op(OP_SLL, 32'h1234, 32'hFFFF_FFE0, r, br, er, lat);
    check("sll0_res", r, 32'h1234); check("sll0_lat", lat, 1);
    run_op(OP_BLT, 32'hFFFF_FFFF, 32'h1, r, br, er, lat);
    check("blt_br", br, 1'b1);
    run_op(OP_BLTU, 32'hFFFF_FFFF, 32'h1, r, br, er, lat);
    check("bltu_br", br, 1'b0);
    run_op(OP_BEQ, 32'h5A5A_5A5A, 32'h5A5A_5A5A, r, br, er, lat);
    check("beq_br", br, 1'b1); check("beq_res", r, 32'd0);
    run_op(16'h0003, 32'h7, 32'h9, r, br, er, lat);
    check("ill2_err", er, 1'b1); check("ill2_res", r, 32'd0); check("ill2_lat", lat, 1);
    run_op(16'h0000, 32'h7, 32'h9, r, br, er, lat);
    check("ill0_err", er, 1'b1);

    // start_i held high through a 10-cycle shift: the next op waits for IDLE.
    wait_ready();
    start_i = 1'b1; op_i = OP_SLL; a_i = $urandom; b_i = 32'd10;
    @(posedge clk_i);
    d1 = 0; d2 = 0; nd = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk_i);
      if (c == 1) begin op_i = OP_ADD; a_i = 32'd40; b_i = 32'd2; end
      if (done_o) begin
        nd++;
        if (d1 == 0) d1 = c; else if (d2 == 0) d2 = c;
      end
      if (c == 13) start_i = 1'b0;
    end
    check("guard_first_done", d1, 11);
    check("guard_second_done", d2, 13);
    check("guard_done_count", nd, 2);

    for (int i = 0; i < 300; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'(1 << $urandom_range(0, 15));
      rb  = $urandom;
      if ($urandom_range(0, 1) == 0) rb[4:0] = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 2) == 0 ? 32'd0 : $urandom;
      run_op(rop, $urandom, rb, r, br, er, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

    repeat (3) @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
